// File: rtl/soc2_uart_tx.sv
// soc2_uart_tx: FIFO-buffered 8-bit UART transmitter, 8N1 by default.
// Define SOC2_UART_TX_PARITY_EN to add an even-parity bit (8E1 framing).
module soc2_uart_tx #(
    parameter int unsigned CLK_DIV    = 217,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        tx_busy,
    output logic                        uart_tx
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef SOC2_UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             uart_tx_q, uart_tx_d;
    logic             tx_ready_q, tx_ready_d;
    logic             tx_busy_q, tx_busy_d;
`ifdef SOC2_UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif
    logic             push_c;
    logic             pop_c;
    logic             bit_done_c;
    logic             fifo_empty_c;

    assign push_c       = tx_valid && (level_q < LVL_FULL);
    assign fifo_empty_c = (level_q == '0);
    assign bit_done_c   = (cnt_q == '0);

    assign tx_ready   = tx_ready_q;
    assign fifo_level = level_q;
    assign tx_busy    = tx_busy_q;
    assign uart_tx    = uart_tx_q;

    // State register; reset returns the FSM to IDLE immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and FIFO pop decision; a pop always coincides with entering START.
    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty_c) begin
                    state_d = S_START;
                    pop_c   = 1'b1;
                end
            end
            S_START: begin
                if (bit_done_c) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_done_c && (bit_idx_q == 3'd7)) begin
`ifdef SOC2_UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef SOC2_UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done_c) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_done_c) begin
                    if (!fifo_empty_c) begin
                        state_d = S_START;
                        pop_c   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: FIFO pointers, bit timing, shift register and line level.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        uart_tx_d = 1'b1;
`ifdef SOC2_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);

        if (pop_c) begin
            shift_d = mem_q[rd_ptr_q];
`ifdef SOC2_UART_TX_PARITY_EN
            parity_d = ^mem_q[rd_ptr_q];
`endif
        end else if ((state_q == S_DATA) && bit_done_c) begin
            shift_d = {1'b0, shift_q[7:1]};
        end

        if ((state_q == S_DATA) && bit_done_c) bit_idx_d = bit_idx_q + 3'd1;

        // Every bit boundary (and idle) reloads the counter so each bit lasts CLK_DIV cycles.
        if ((state_q == S_IDLE) || bit_done_c) begin
            cnt_d = CNT_RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        unique case (state_d)
            S_START:  uart_tx_d = 1'b0;
            S_DATA:   uart_tx_d = shift_d[0];
`ifdef SOC2_UART_TX_PARITY_EN
            S_PARITY: uart_tx_d = parity_q;
`endif
            default:  uart_tx_d = 1'b1;
        endcase

        tx_ready_d = (level_d < LVL_FULL);
        tx_busy_d  = (state_d != S_IDLE) || (level_d != '0);
    end

    // Datapath and output registers; reset drops the frame and empties the FIFO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            cnt_q      <= '0;
            uart_tx_q  <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
`ifdef SOC2_UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            cnt_q      <= cnt_d;
            uart_tx_q  <= uart_tx_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
`ifdef SOC2_UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // FIFO storage; contents need no reset since the level gates every read.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= tx_data;
    end

endmodule
